// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter (debug FSM states, default widths,
// starvation counter width).
package dram_arb_pkg;

  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_DATA_W   = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_DONE = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/dram_starve_counter.sv
// Saturating count of consecutive cycles the CPU beat a pending debug request;
// at_limit tells the arbiter to force the debug port in.
module dram_starve_counter
  import dram_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dbg_valid,
  input  logic cpu_req,
  input  logic dbg_grant,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE = STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] cnt_reg;
  logic [STARVE_CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (dbg_grant || !dbg_valid) begin
      cnt_next = '0;
    end else if (cpu_req && (cnt_reg != LIMIT_V)) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign at_limit = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data RAM between the MEM stage (priority) and a debug/loader port.
// Define DRAM_ARB_STARVE_EN to compile in the starvation counter that forces debug grants.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  dbg_state_t        state_reg;
  logic              dbg_done_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;
  logic              force_dbg;
  logic              dbg_grant;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("dram_arbiter: STARVE_LIMIT must be within 1..15");
  end

`ifdef DRAM_ARB_STARVE_EN
  dram_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .dbg_valid(dbg_valid),
    .cpu_req  (cpu_req),
    .dbg_grant(dbg_grant),
    .at_limit (force_dbg)
  );

  assign cpu_stall = dbg_grant && cpu_req;
`else
  // Without the counter debug only ever gets idle CPU slots, so the pipeline never freezes.
  assign force_dbg = 1'b0;
  assign cpu_stall = 1'b0;
`endif

  // D_DONE blocks a grant so consecutive debug accesses always leave a CPU slot between them.
  assign dbg_grant = dbg_valid && (state_reg != D_DONE) && (!cpu_req || force_dbg);
  assign dbg_ready = dbg_grant;

  assign ram_addr  = dbg_grant ? dbg_addr  : cpu_addr;
  assign ram_wdata = dbg_grant ? dbg_wdata : cpu_wdata;
  assign ram_we    = dbg_grant ? dbg_we    : (cpu_req && cpu_we);
  assign cpu_rdata = ram_rdata;

  // A reset landing while the pulse is up swallows it; the RAM write has already happened.
  assign dbg_done  = dbg_done_reg && !reset;
  assign dbg_rdata = dbg_rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= D_IDLE;
      dbg_done_reg  <= 1'b0;
      dbg_rdata_reg <= '0;
    end else begin
      dbg_done_reg <= dbg_grant;
      if (dbg_grant) begin
        dbg_rdata_reg <= ram_rdata;
      end
      case (state_reg)
        D_IDLE: begin
          if (dbg_grant) begin
            state_reg <= D_DONE;
          end else if (dbg_valid) begin
            state_reg <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (dbg_grant) begin
            state_reg <= D_DONE;
          end else if (!dbg_valid) begin
            state_reg <= D_IDLE;
          end
        end
        D_DONE:  state_reg <= D_IDLE;
        default: state_reg <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: behavioural RAM, shadow memory model and
// read-data scoreboards for the CPU and debug ports.
module tb_dram_arbiter;

  localparam int ADDR_W       = 6;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
`ifdef DRAM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
  localparam int GRANT_CYC = STARVE_LIMIT;
`else
  localparam bit STARVE_EN = 1'b0;
  localparam int GRANT_CYC = 20;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dbg_valid;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ready;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem     [64];
  logic [DATA_W-1:0] exp_mem [64];
  logic [DATA_W-1:0] cpu_q[$];
  logic [DATA_W-1:0] dbg_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready),
    .dbg_done (dbg_done),
    .dbg_rdata(dbg_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM: asynchronous read, write at the clock edge (read-during-write sees old word)
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_pop_check(input string tag);
    logic [DATA_W-1:0] e;
    if (cpu_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got=%h expected=<cpu scoreboard empty>", tag, cpu_rdata);
    end else begin
      e = cpu_q.pop_front();
      check(tag, cpu_rdata, e);
    end
  endtask

  task automatic dbg_pop_check(input string tag);
    logic [DATA_W-1:0] e;
    if (dbg_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got=%h expected=<dbg scoreboard empty>", tag, dbg_rdata);
    end else begin
      e = dbg_q.pop_front();
      check(tag, dbg_rdata, e);
    end
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    check("cpu_wr_stall", 32'(cpu_stall), 32'(0));
    check("cpu_wr_ram_we", 32'(ram_we), 32'(1));
    check("cpu_wr_ram_addr", 32'(ram_addr), 32'(a));
    exp_mem[a] = d;
    $display("txn cpu_wr addr=%0d data=%h", a, d);
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    cpu_q.push_back(exp_mem[a]);
    @(negedge clk);
    check("cpu_rd_stall", 32'(cpu_stall), 32'(0));
    cpu_pop_check("cpu_rd_data");
    $display("txn cpu_rd addr=%0d data=%h", a, cpu_rdata);
    next_cycle();
    cpu_req = 1'b0;
  endtask

  // Debug access with the CPU idle: granted in the same cycle, done one cycle later
  task automatic dbg_access(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    dbg_valid = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    check("dbg_idle_ready", 32'(dbg_ready), 32'(1));
    check("dbg_idle_stall", 32'(cpu_stall), 32'(0));
    dbg_q.push_back(exp_mem[a]);
    if (we) exp_mem[a] = d;
    next_cycle();
    dbg_valid = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    check("dbg_idle_done", 32'(dbg_done), 32'(1));
    dbg_pop_check("dbg_idle_rdata");
    $display("txn dbg_%s addr=%0d rdata=%h", we ? "wr" : "rd", a, dbg_rdata);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset state
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_dbg_done", 32'(dbg_done), 32'(0));
    check("rst_dbg_ready", 32'(dbg_ready), 32'(0));
    check("rst_cpu_stall", 32'(cpu_stall), 32'(0));
    check("rst_ram_we", 32'(ram_we), 32'(0));
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
    $display("txn reset");
    next_cycle();
    reset = 1'b0;

    // CPU store then load
    cpu_write(6'd5, 32'hDEADBEEF);
    cpu_read(6'd5);

    // Idle-CPU debug read, then a debug write that captures the old word
    dbg_access(1'b0, 6'd5, '0);
    dbg_access(1'b1, 6'd5, 32'h0BADC0DE);
    cpu_read(6'd5);

    // Debug write against continuous CPU traffic
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h12345678;
    cpu_we = 1'b0; cpu_addr = 6'd0;
    for (int c = 0; c <= GRANT_CYC; c++) begin
      cpu_req = STARVE_EN ? 1'b1 : (c < GRANT_CYC);
      @(negedge clk);
      check($sformatf("starve_ready_c%0d", c), 32'(dbg_ready), 32'(c == GRANT_CYC));
      check($sformatf("starve_stall_c%0d", c), 32'(cpu_stall), 32'(STARVE_EN && (c == GRANT_CYC)));
      if (c == GRANT_CYC) begin
        check("starve_ram_we", 32'(ram_we), 32'(1));
        check("starve_ram_addr", 32'(ram_addr), 32'(9));
        dbg_q.push_back(exp_mem[9]);
        exp_mem[9] = 32'h12345678;
      end
      next_cycle();
    end
    dbg_valid = 1'b0; dbg_we = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("starve_done", 32'(dbg_done), 32'(1));
    check("starve_stall_after", 32'(cpu_stall), 32'(0));
    dbg_pop_check("starve_rdata");
    $display("txn dbg_wr_starved addr=9 grant_cycle=%0d", GRANT_CYC);
    next_cycle();
    cpu_read(6'd9);

    // Back-to-back debug requests with dbg_valid held
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd3; dbg_wdata = 32'hA5A50003;
    @(negedge clk);
    check("b2b_ready_t0", 32'(dbg_ready), 32'(1));
    dbg_q.push_back(exp_mem[3]);
    exp_mem[3] = 32'hA5A50003;
    next_cycle();
    dbg_we = 1'b0;
    @(negedge clk);
    check("b2b_ready_t1", 32'(dbg_ready), 32'(0));
    check("b2b_done_t1", 32'(dbg_done), 32'(1));
    dbg_pop_check("b2b_rdata_t1");
    next_cycle();
    @(negedge clk);
    check("b2b_ready_t2", 32'(dbg_ready), 32'(1));
    check("b2b_done_t2", 32'(dbg_done), 32'(0));
    dbg_q.push_back(exp_mem[3]);
    next_cycle();
    dbg_valid = 1'b0;
    @(negedge clk);
    check("b2b_done_t3", 32'(dbg_done), 32'(1));
    dbg_pop_check("b2b_rdata_t3");
    $display("txn dbg_b2b addr=3 rdata=%h", dbg_rdata);
    next_cycle();

    // Reset in the cycle after a debug write grant
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd5; dbg_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rstmid_ready", 32'(dbg_ready), 32'(1));
    exp_mem[5] = 32'hCAFEF00D;
    next_cycle();
    dbg_valid = 1'b0; dbg_we = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rstmid_done_in_reset", 32'(dbg_done), 32'(0));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_done_after", 32'(dbg_done), 32'(0));
    check("rstmid_rdata_cleared", dbg_rdata, 32'h0);
    $display("txn reset_mid_dbg_write addr=5");
    next_cycle();
    dbg_access(1'b0, 6'd5, '0);
    cpu_read(6'd5);

    check("cpu_q_drained", 32'(cpu_q.size()), 32'(0));
    check("dbg_q_drained", 32'(dbg_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Arbiter sharing the single-port 64-word data RAM between the pipeline MEM stage and a debug/loader port. The MEM stage has priority. A starvation counter guarantees the debug port a slot; when it takes that slot, the pipeline is frozen for one cycle via `cpu_stall`. The block sits between the EX/MEM pipeline register and the data RAM, and drives the RAM address, write-data and write-enable pins.

## Interface
- `ADDR_W`, default 6: word-address width (RAM index = `ALUResult_mem[7:2]`).
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: consecutive CPU-won cycles before debug is forced in (legal range 1–15).

One clock; reset is synchronous and active-high.

- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous active-high reset.
- `cpu_req`, in, 1: MEM stage accesses RAM this cycle (MemRead_mem | MemWrite_mem).
- `cpu_we`, in, 1: MEM stage write.
- `cpu_addr`, in, ADDR_W: MEM stage word address.
- `cpu_wdata`, in, DATA_W: MEM stage store data.
- `cpu_rdata`, out, DATA_W: RAM read data to the MEM stage.
- `cpu_stall`, out, 1: pipeline freeze; the MEM-stage access is not performed this cycle.
- `dbg_valid`, in, 1: debug request pending.
- `dbg_we`, in, 1: debug write.
- `dbg_addr`, in, ADDR_W: debug word address.
- `dbg_wdata`, in, DATA_W: debug write data.
- `dbg_ready`, out, 1: debug request granted this cycle.
- `dbg_done`, out, 1: one-cycle completion pulse.
- `dbg_rdata`, out, DATA_W: captured read data, valid while `dbg_done` is high.
- `ram_addr`, out, ADDR_W: RAM address.
- `ram_wdata`, out, DATA_W: RAM write data.
- `ram_we`, out, 1: RAM write enable.
- `ram_rdata`, in, DATA_W: RAM asynchronous read data.

## Operation
- **Grant is decided combinationally each cycle**; the RAM is driven by the winner.
  - Debug wins when `dbg_valid` && state != D_DONE, and either `!cpu_req` or the starvation counter equals STARVE_LIMIT.
  - Otherwise the CPU owns the RAM.
- **Debug win:**
  - `dbg_ready`=1.
  - RAM driven from the `dbg_*` inputs.
  - `cpu_stall`=1 only if `cpu_req`=1.
- **CPU win:**
  - RAM driven from the `cpu_*` inputs.
  - `ram_we` = `cpu_req` & `cpu_we`.
- `cpu_rdata` = `ram_rdata` at all times. It is meaningful only when the CPU wins.
- **Debug FSM:**
  - D_IDLE → D_WAIT when `dbg_valid` is high and not granted.
  - D_IDLE or D_WAIT → D_DONE on grant.
  - D_DONE → D_IDLE unconditionally.
  - `dbg_ready` is forced low in D_DONE, so back-to-back debug accesses always leave one CPU slot between them.
- **Starvation counter:**
  - Width 4 bits.
  - Increments when `dbg_valid` && `cpu_req` && debug not granted.
  - Clears on debug grant or when `dbg_valid` is low.
  - Saturates at STARVE_LIMIT.
- On a debug grant, `ram_rdata` is registered into `dbg_rdata`, which holds until the next grant.
- Handshake: the debug master holds `dbg_valid` and all fields stable until `dbg_ready`. Transfer occurs when `dbg_valid` && `dbg_ready`.

## Timing
- Reset values:
  - State D_IDLE, counter 0.
  - `dbg_done`=0, `dbg_rdata`=0.
  - `cpu_stall`, `dbg_ready` and `ram_we` follow the combinational rules with state D_IDLE and counter 0.
- Debug latency:
  - Grant is in the same cycle as `dbg_valid` when the CPU is idle.
  - Worst case, grant is STARVE_LIMIT cycles after `dbg_valid` rises under continuous `cpu_req`.
  - `dbg_done` is asserted exactly 1 cycle after the grant.
- Writes commit at the grant-cycle clock edge. The RAM read-during-write result is the old word.
- Reset during D_DONE: the `dbg_done` pulse is suppressed, but a write already committed stays committed.
- Simultaneous `cpu_req` and `dbg_valid` with the counter below the limit: the CPU wins and the counter increments.

## Configuration
- `DRAM_ARB_STARVE_EN` defined: the starvation counter and forced debug grants are compiled in, as described above.
- `DRAM_ARB_STARVE_EN` undefined:
  - The counter is removed.
  - Debug is granted only when `cpu_req` is low.
  - `cpu_stall` is tied to 0.
  - Debug may starve indefinitely.

## Structure
- Package `dram_arb_pkg`:
  - Debug FSM state enum (D_IDLE, D_WAIT, D_DONE).
  - Default ADDR_W / DATA_W constants.
  - Counter width constant.
- One natural sub-module, `dram_starve_counter`: the saturating counter plus the limit compare, instantiated only when `DRAM_ARB_STARVE_EN` is defined.

## Test plan
- **CPU-only store then load.** `cpu_req`=1, `cpu_we`=1, addr 5, data 0xDEADBEEF; next cycle a read of addr 5 → `cpu_rdata`=0xDEADBEEF, `cpu_stall`=0 throughout.
- **Idle-CPU debug read.** Debug read of addr 5 with `cpu_req`=0 → `dbg_ready` in the same cycle, `dbg_done` next cycle, `dbg_rdata`=0xDEADBEEF.
- **Starvation with STARVE_LIMIT=4.** `cpu_req` continuously high and a debug write of 0x12345678 to addr 9 → CPU wins for 4 cycles, debug is granted on the 5th with `cpu_stall`=1 for exactly that cycle, and a later read of addr 9 returns 0x12345678.
- **Back-to-back debug.** `dbg_valid` held for two requests with the CPU idle → grants at cycles t and t+2, and `dbg_ready`=0 at t+1.
- **Reset mid-operation.** Reset asserted in the cycle after a debug write grant → no `dbg_done`, state D_IDLE, `dbg_rdata`=0, and the written word is retained.
- **Macro undefined.** Continuous `cpu_req` with a pending debug request → `dbg_ready` never asserts and `cpu_stall` stays 0 for 20 cycles; the grant occurs on the first cycle `cpu_req` drops.
